// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with 3-sample majority vote per bit and stop-bit check.
// Latency: valid rises one clk after the stop-bit vote tick.
// Backpressure: one-word output register; a word that completes while valid=1 & ready=0 is dropped and overrun pulses.
//
// Ports:
//   clk         system clock
//   reset_n     synchronous active-low reset
//   baud_tick   one-clk enable strobe, OVERSAMPLE strobes per bit period
//   rxd         asynchronous serial input (idle high, or idle low when INVERT=1)
//   data        received word, LSB first on the line, stable while valid=1
//   valid       word available, held until valid&ready
//   ready       consumer accepts the word when valid&ready
//   frame_err   one-clk pulse: stop bit voted 0
//   overrun     one-clk pulse: word completed while valid=1 & ready=0
//   parity_odd  (UART_RX_PARITY_EN only) 1=odd, 0=even parity, captured at start-bit detection
//   parity_err  (UART_RX_PARITY_EN only) one-clk pulse: parity bit mismatch
//
// Optional feature: define UART_RX_PARITY_EN to insert a parity bit between the data bits and the stop bit.

module uart_rx_os #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter bit INVERT     = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 baud_tick,
  input  logic                 rxd,
`ifdef UART_RX_PARITY_EN
  input  logic                 parity_odd,
  output logic                 parity_err,
`endif
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  // Tick positions inside one bit period; the vote is taken on the third sample tick.
  localparam logic [CW-1:0] LP_LAST   = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] LP_MID_M1 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LP_MID    = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] LP_MID_P1 = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] LP_LAST_BIT = BW'(DATA_BITS - 1);

  // Raw idle level of rxd; the synchroniser is preset to it so reset never looks like a start edge.
  localparam logic LP_IDLE_RAW = ~INVERT;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_IDLE
  } state_t;
`endif

  state_t r_state;
  state_t w_state_nxt;

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 w_line;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        w_idx;
  logic [BW-1:0]        r_bit_cnt;
  logic [1:0]           r_samp;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_armed;

  logic                 w_vote;
  logic                 w_vote_tick;
  logic                 w_bit_end;
  logic                 w_last_bit;
  logic                 w_par_ok;

  logic                 w_start_det;
  logic                 w_shift_en;
  logic                 w_bit_adv;
  logic                 w_word_done;
  logic                 w_frame_bad;

  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_frame_err;
  logic                 r_overrun;

`ifdef UART_RX_PARITY_EN
  logic r_par_odd;
  logic r_par_acc;
  logic r_par_bad;
  logic r_parity_err;
  logic w_par_chk;
  logic w_par_mismatch;
`endif

  // ---------------------------------------------------------------------------
  // Line synchroniser; after the XOR the internal line is always idle-high.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync1 <= LP_IDLE_RAW;
      r_sync2 <= LP_IDLE_RAW;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
    end
  end

  assign w_line = r_sync2 ^ INVERT;

  // Index of the current tick within the bit: r_cnt holds the index of the previous tick.
  assign w_idx       = (r_cnt == LP_LAST) ? '0 : r_cnt + CW'(1);
  assign w_vote_tick = (w_idx == LP_MID_P1);
  assign w_bit_end   = (w_idx == LP_LAST);
  assign w_last_bit  = (r_bit_cnt == LP_LAST_BIT);

  // Majority of the samples at mid-1, mid and the live sample at mid+1.
  assign w_vote = (r_samp[0] & r_samp[1]) | (r_samp[0] & w_line) | (r_samp[1] & w_line);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_det = 1'b0;
    w_shift_en  = 1'b0;
    w_bit_adv   = 1'b0;
    w_word_done = 1'b0;
    w_frame_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_chk   = 1'b0;
`endif
    if (baud_tick) begin
      case (r_state)
        S_IDLE: begin
          // r_armed requires the line to have been seen high since reset, so a
          // release in the middle of a frame waits for a genuine falling edge.
          if (r_armed && !w_line) begin
            w_state_nxt = S_START;
            w_start_det = 1'b1;
          end
        end
        S_START: begin
          if (w_vote_tick && w_vote) begin
            w_state_nxt = S_IDLE;          // glitch: silently ignore
          end else if (w_bit_end) begin
            w_state_nxt = S_DATA;
          end
        end
        S_DATA: begin
          if (w_vote_tick) begin
            w_shift_en = 1'b1;
          end
          if (w_bit_end) begin
            if (w_last_bit) begin
`ifdef UART_RX_PARITY_EN
              w_state_nxt = S_PARITY;
`else
              w_state_nxt = S_STOP;
`endif
            end else begin
              w_bit_adv = 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_vote_tick) begin
            w_par_chk = 1'b1;
          end
          if (w_bit_end) begin
            w_state_nxt = S_STOP;
          end
        end
`endif
        S_STOP: begin
          // Leaving at mid-bit gives half a bit of slack for the next start edge.
          if (w_vote_tick) begin
            if (w_vote) begin
              w_word_done = w_par_ok;
              w_state_nxt = S_IDLE;
            end else begin
              w_frame_bad = 1'b1;
              w_state_nxt = S_WAIT_IDLE;
            end
          end
        end
        S_WAIT_IDLE: begin
          // A break holds the line low; only one frame_err is raised for it.
          if (w_line) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Bit timing, sampling and shift register; all frozen when baud_tick=0.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      r_samp    <= '0;
      r_shift   <= '0;
      r_armed   <= 1'b0;
    end else if (baud_tick) begin
      if (w_line) begin
        r_armed <= 1'b1;
      end
      if (w_start_det) begin
        r_cnt     <= '0;
        r_bit_cnt <= '0;
      end else if (r_state != S_IDLE) begin
        r_cnt <= w_idx;
        if (w_idx == LP_MID_M1) begin
          r_samp[0] <= w_line;
        end
        if (w_idx == LP_MID) begin
          r_samp[1] <= w_line;
        end
        if (w_bit_adv) begin
          r_bit_cnt <= r_bit_cnt + BW'(1);
        end
      end
      // LSB arrives first, so shift right and insert at the top.
      if (w_shift_en) begin
        r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // ---------------------------------------------------------------------------
  // Parity: running XOR of data bits, compared against the voted parity bit.
  // ---------------------------------------------------------------------------
  assign w_par_mismatch = ((r_par_acc ^ w_vote) != r_par_odd);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_par_odd    <= 1'b0;
      r_par_acc    <= 1'b0;
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= w_par_chk & w_par_mismatch;
      if (w_start_det) begin
        r_par_odd <= parity_odd;
        r_par_acc <= 1'b0;
        r_par_bad <= 1'b0;
      end else begin
        if (w_shift_en) begin
          r_par_acc <= r_par_acc ^ w_vote;
        end
        if (w_par_chk && w_par_mismatch) begin
          r_par_bad <= 1'b1;
        end
      end
    end
  end

  assign w_par_ok   = ~r_par_bad;
  assign parity_err = r_parity_err;
`else
  assign w_par_ok = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Output holding register and handshake; runs every clk regardless of baud_tick.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_frame_bad;
      r_overrun   <= w_word_done & r_valid & ~ready;
      if (w_word_done && (!r_valid || ready)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: drives two receivers (8N1/x16 idle-high, 7-bit/x8 idle-low) with framed serial data.
// Latency: expectations are queued when a frame is launched; a monitor pops them as outputs appear.
// Backpressure: ready is held low for the overrun scenario, otherwise the consumer is always ready.

module tb_uart_rx_os;

  localparam int NB_A = 8;
  localparam int OS_A = 16;
  localparam int NB_B = 7;
  localparam int OS_B = 8;

  localparam int EV_FERR = 1;
  localparam int EV_OVR  = 2;
  localparam int EV_PERR = 3;

  logic       clk       = 1'b0;
  logic       reset_n   = 1'b0;
  logic       baud_tick = 1'b0;
  logic       rxd_a     = 1'b1;   // idle high
  logic       rxd_b     = 1'b0;   // inverted line idles low
  logic       ready_a   = 1'b1;
  logic       ready_b   = 1'b1;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic       valid_a, valid_b;
  logic       ferr_a, ferr_b;
  logic       ovr_a, ovr_b;
  logic       perr_a, perr_b;
`ifdef UART_RX_PARITY_EN
  logic       par_odd = 1'b0;
`else
  assign perr_a = 1'b0;
  assign perr_b = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;
  int n_acc[2];
  int n_ferr[2];
  int n_ovr[2];

  logic [8:0] q_word_a[$];
  logic [8:0] q_word_b[$];
  int         q_evt_a[$];
  int         q_evt_b[$];
  bit         pend_a = 1'b0;   // model: a word is being held with ready low
  bit         pend_b = 1'b0;

  uart_rx_os dut_a (
    .clk       (clk),
    .reset_n   (reset_n),
    .baud_tick (baud_tick),
    .rxd       (rxd_a),
`ifdef UART_RX_PARITY_EN
    .parity_odd(par_odd),
    .parity_err(perr_a),
`endif
    .data      (data_a),
    .valid     (valid_a),
    .ready     (ready_a),
    .frame_err (ferr_a),
    .overrun   (ovr_a)
  );

  uart_rx_os #(.DATA_BITS(NB_B), .OVERSAMPLE(OS_B), .INVERT(1'b1)) dut_b (
    .clk       (clk),
    .reset_n   (reset_n),
    .baud_tick (baud_tick),
    .rxd       (rxd_b),
`ifdef UART_RX_PARITY_EN
    .parity_odd(par_odd),
    .parity_err(perr_b),
`endif
    .data      (data_b),
    .valid     (valid_b),
    .ready     (ready_b),
    .frame_err (ferr_b),
    .overrun   (ovr_b)
  );

  always #5 clk = ~clk;

  // Irregular tick pattern so that hold behaviour between ticks is exercised.
  always @(negedge clk) baud_tick = ($urandom_range(0, 1) == 1);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_evt(input int w, input int code);
    if (w == 0) q_evt_a.push_back(code);
    else        q_evt_b.push_back(code);
  endtask

  task automatic pop_evt(input int w, input int code, input string nm);
    int e;
    checks++;
    if ((w == 0 && q_evt_a.size() == 0) || (w == 1 && q_evt_b.size() == 0)) begin
      failures++;
      $display("FAIL %s dut%0d: got an unexpected pulse, required none", nm, w);
    end else begin
      if (w == 0) e = q_evt_a.pop_front();
      else        e = q_evt_b.pop_front();
      if (e != code) begin
        failures++;
        $display("FAIL %s dut%0d: got pulse kind %0d, required kind %0d", nm, w, code, e);
      end
    end
  endtask

  task automatic mon(input int w, input logic v, input logic r, input logic [8:0] d,
                     input logic fe, input logic ov, input logic pe);
    logic [8:0] e;
    if (v && r) begin
      n_acc[w]++;
      checks++;
      if ((w == 0 && q_word_a.size() == 0) || (w == 1 && q_word_b.size() == 0)) begin
        failures++;
        $display("FAIL word dut%0d: got unexpected word 0x%0h, required none", w, d);
      end else begin
        if (w == 0) e = q_word_a.pop_front();
        else        e = q_word_b.pop_front();
        if (d !== e) begin
          failures++;
          $display("FAIL word dut%0d: got 0x%0h, required 0x%0h", w, d, e);
        end
      end
    end
    if (fe) begin n_ferr[w]++; pop_evt(w, EV_FERR, "frame_err"); end
    if (ov) begin n_ovr[w]++;  pop_evt(w, EV_OVR, "overrun");    end
    if (pe) pop_evt(w, EV_PERR, "parity_err");
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      mon(0, valid_a, ready_a, {1'b0, data_a}, ferr_a, ovr_a, perr_a);
      mon(1, valid_b, ready_b, {2'b00, data_b}, ferr_b, ovr_b, perr_b);
    end
  end

  // Waits for n clocks that carry baud_tick, then steps 1 unit past the edge.
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!baud_tick) @(posedge clk);
    end
    #1;
  endtask

  // Drives a logical line level (idle = 1) for n ticks; dut_b's wire is inverted.
  task automatic drive(input int w, input bit b, input int n);
    if (w == 0) rxd_a = b;
    else        rxd_b = ~b;
    wait_ticks(n);
  endtask

  // Sends one frame and queues what the receiver must report for it.
  task automatic send_frame(input int w, input logic [8:0] d, input bit stop_ok, input bit par_ok);
    int         nb;
    int         os;
    logic [8:0] m;
    bit         rdy;
    bit         bad_par;
    nb  = (w == 0) ? NB_A : NB_B;
    os  = (w == 0) ? OS_A : OS_B;
    m   = d & ((9'd1 << nb) - 9'd1);
    rdy = (w == 0) ? ready_a : ready_b;
    bad_par = ~par_ok;
    if (bad_par) push_evt(w, EV_PERR);
    if (!stop_ok) begin
      push_evt(w, EV_FERR);
    end else if (!bad_par) begin
      if (!rdy && ((w == 0) ? pend_a : pend_b)) begin
        push_evt(w, EV_OVR);
      end else begin
        if (w == 0) q_word_a.push_back(m);
        else        q_word_b.push_back(m);
        if (!rdy) begin
          if (w == 0) pend_a = 1'b1;
          else        pend_b = 1'b1;
        end
      end
    end
    drive(w, 1'b0, os);
    for (int i = 0; i < nb; i++) drive(w, m[i], os);
`ifdef UART_RX_PARITY_EN
    begin
      bit pbit;
      // Parity bit makes the total count of ones odd (odd mode) or even.
      pbit = (($countones(m) % 2) == 1) ? ~par_odd : par_odd;
      drive(w, pbit ^ bad_par, os);
    end
`endif
    drive(w, stop_ok, os);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion, required completion before time limit");
    $fatal(1);
  end

  initial begin
    int a0, f0;
    logic [8:0] d;
    bit s_ok, p_ok;
    for (int i = 0; i < 2; i++) begin n_acc[i] = 0; n_ferr[i] = 0; n_ovr[i] = 0; end

    // Reset state
    repeat (5) @(posedge clk);
    #1;
    check("reset_valid_a", valid_a, 0);
    check("reset_data_a", data_a, 0);
    check("reset_ferr_a", ferr_a, 0);
    check("reset_ovr_a", ovr_a, 0);
    check("reset_valid_b", valid_b, 0);
    check("reset_data_b", data_b, 0);
    reset_n = 1'b1;
    wait_ticks(20);

    // Basic 8N1 word
    send_frame(0, 9'h0A5, 1'b1, 1'b1);
    drive(0, 1'b1, 6);
    check("a5_data_held", data_a, 8'hA5);
    check("a5_valid_dropped", valid_a, 0);

    // Start-bit glitch
    a0 = n_acc[0]; f0 = n_ferr[0];
    drive(0, 1'b0, 3);
    drive(0, 1'b1, 40);
    check("glitch_no_word", n_acc[0], a0);
    check("glitch_no_ferr", n_ferr[0], f0);

    // Bad stop then a 40-bit break
    a0 = n_acc[0]; f0 = n_ferr[0];
    send_frame(0, 9'h03C, 1'b0, 1'b1);
    drive(0, 1'b0, 40 * OS_A);
    drive(0, 1'b1, 8);
    check("break_one_ferr", n_ferr[0], f0 + 1);
    check("break_no_word", n_acc[0], a0);
    send_frame(0, 9'h03C, 1'b1, 1'b1);
    drive(0, 1'b1, 6);
    check("after_break_data", data_a, 8'h3C);

    // Overrun with ready low, back-to-back frames
    ready_a = 1'b0;
    send_frame(0, 9'h011, 1'b1, 1'b1);
    send_frame(0, 9'h022, 1'b1, 1'b1);
    drive(0, 1'b1, 5);
    check("ovr_valid_held", valid_a, 1);
    check("ovr_data_old", data_a, 8'h11);
    check("ovr_one_pulse", n_ovr[0], 1);
    ready_a = 1'b1;
    pend_a  = 1'b0;
    @(posedge clk);
    #1;
    check("ovr_valid_drop", valid_a, 0);
    check("ovr_data_kept", data_a, 8'h11);

    // Random traffic on the 8-bit receiver
    for (int i = 0; i < 25; i++) begin
      d    = 9'($urandom_range(0, 255));
      s_ok = ($urandom_range(0, 5) != 0);
      p_ok = 1'b1;
`ifdef UART_RX_PARITY_EN
      p_ok    = ($urandom_range(0, 5) != 0);
      par_odd = ($urandom_range(0, 1) == 1);
`endif
      send_frame(0, d, s_ok, p_ok);
      drive(0, 1'b1, s_ok ? $urandom_range(0, 6) : $urandom_range(4, 10));
    end

    // Inverted 7-bit receiver
    wait_ticks(10);
    send_frame(1, 9'h055, 1'b1, 1'b1);
    drive(1, 1'b1, 6);
    check("b_data_55", data_b, 7'h55);

    // Reset in the middle of a frame
    drive(1, 1'b0, OS_B);
    drive(1, 1'b1, OS_B);
    drive(1, 1'b0, OS_B);
    reset_n = 1'b0;
    rxd_b   = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midreset_valid_b", valid_b, 0);
    check("midreset_data_b", data_b, 0);
    reset_n = 1'b1;
    drive(1, 1'b1, 20);
    send_frame(1, 9'h02A, 1'b1, 1'b1);
    drive(1, 1'b1, 6);
    check("b_data_2a", data_b, 7'h2A);

    for (int i = 0; i < 12; i++) begin
      d    = 9'($urandom_range(0, 127));
      s_ok = ($urandom_range(0, 5) != 0);
      p_ok = 1'b1;
`ifdef UART_RX_PARITY_EN
      p_ok    = ($urandom_range(0, 5) != 0);
      par_odd = ($urandom_range(0, 1) == 1);
`endif
      send_frame(1, d, s_ok, p_ok);
      drive(1, 1'b1, s_ok ? $urandom_range(0, 4) : $urandom_range(4, 8));
    end

`ifdef UART_RX_PARITY_EN
    // Odd parity on 0x0F: correct parity bit is 1
    par_odd = 1'b1;
    a0 = n_acc[0];
    send_frame(0, 9'h00F, 1'b1, 1'b0);
    drive(0, 1'b1, 6);
    check("perr_no_word", n_acc[0], a0);
    send_frame(0, 9'h00F, 1'b1, 1'b1);
    drive(0, 1'b1, 6);
    check("par_ok_data", data_a, 8'h0F);
`endif

    // Everything queued must have been seen
    wait_ticks(40);
    check("drain_word_a", q_word_a.size(), 0);
    check("drain_word_b", q_word_b.size(), 0);
    check("drain_evt_a", q_evt_a.size(), 0);
    check("drain_evt_b", q_evt_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
